// File: rtl/nonce_catch_fifo.sv
// Catches finished hash-core jobs into per-core hold slots, then round-robins them into a FWFT result FIFO.
// Latency: busy fall at edge k -> rd_valid after edge k+1; a full FIFO holds slots pending, a slot recaptured while pending is a counted drop.
module nonce_catch_fifo #(
   parameter int NUM_CORES    = 4,
   parameter int ID_W         = 4,
   parameter int NONCE_W      = 32,
   parameter int DEPTH        = 8,
   parameter int SUCCESS_ONLY = 0,
   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int EW = 1 + CW + ID_W + NONCE_W,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES-1:0]         start,
   input  logic [NUM_CORES-1:0]         busy,
   input  logic [NUM_CORES-1:0]         success,
   input  logic [NUM_CORES*ID_W-1:0]    hash_id,
   input  logic [NUM_CORES*NONCE_W-1:0] nonce_in,
   input  logic                         flush,
   input  logic                         rd_ready,
   output logic                         rd_valid,
   output logic [EW-1:0]                rd_data,
   output logic [AW:0]                  fifo_count,
   output logic                         overflow,
   output logic [7:0]                   drop_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} core_state_t;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   core_state_t          state_q [NUM_CORES];
   core_state_t          state_d [NUM_CORES];
   logic [NUM_CORES-1:0] cap, pending, pending_d, gnt, drop;
   logic [EW-1:0]        hold [NUM_CORES];
   logic [CW-1:0]        rr_ptr, rr_ptr_d, gnt_idx;
   logic [EW-1:0]        mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 do_wr, do_rd, space;
   logic [3:0]           ndrop;
   logic [8:0]           drop_sum;
   logic [7:0]           drop_next;

   always_comb begin : fsm_next
      for (int i = 0; i < NUM_CORES; i++) begin
         state_d[i] = state_q[i];
         cap[i]     = 1'b0;
         case (state_q[i])
            IDLE:    if (start[i]) state_d[i] = ARMED;
            ARMED:   if (busy[i])  state_d[i] = RUN;
            RUN:     if (!busy[i]) begin
                        state_d[i] = IDLE;
                        cap[i]     = (SUCCESS_ONLY == 0) || success[i];
                     end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Round-robin search begins at rr_ptr, which always names the core after the last grant.
   always_comb begin : arbiter
      int   idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      gnt      = '0;
      gnt_idx  = '0;
      rr_ptr_d = rr_ptr;
      do_rd    = rd_valid & rd_ready;
      space    = (count != CNT_FULL) || do_rd;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (space && !found && pending[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = CW'(idx);
            rr_ptr_d     = (idx == NUM_CORES-1) ? '0 : CW'(idx + 1);
         end
      end
      do_wr = found;
   end

   // A slot granted on the same edge it is recaptured was not lost, so it is not a drop.
   always_comb begin
      pending_d = (pending & ~gnt) | cap;
      drop      = cap & pending & ~gnt;
      ndrop     = '0;
      for (int i = 0; i < NUM_CORES; i++) ndrop = ndrop + 4'(drop[i]);
      drop_sum  = {1'b0, drop_count} + {5'b0, ndrop};
      drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CORES; i++) state_q[i] <= IDLE;
         pending    <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) state_q[i] <= state_d[i];
         if (flush) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
         end else begin
            pending    <= pending_d;
            rr_ptr     <= rr_ptr_d;
            drop_count <= drop_next;
            if (|drop) overflow <= 1'b1;
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_wr && !do_rd)      count <= count + CNT_ONE;
            else if (!do_wr && do_rd) count <= count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CORES; i++) begin
         if (cap[i] && !reset)
            hold[i] <= {success[i], CW'(i), hash_id[i*ID_W +: ID_W], nonce_in[i*NONCE_W +: NONCE_W]};
      end
      if (do_wr && !reset && !flush) mem[wr_ptr] <= hold[gnt_idx];
   end

   assign rd_valid   = (count != '0);
   assign rd_data    = mem[rd_ptr];
   assign fifo_count = count;

endmodule

// File: doc/nonce_catch_fifo.md
NONCE_CATCH_FIFO -- requirements
Module: nonce_catch_fifo

Parameters
REQ-001 SHALL have parameter NUM_CORES, default 4: number of hash cores monitored, legal 1..8.
REQ-002 SHALL have parameter ID_W, default 4: hash_id width per core.
REQ-003 SHALL have parameter NONCE_W, default 32: nonce width per core.
REQ-004 SHALL have parameter DEPTH, default 8: result FIFO entries, power of two, legal 2..16.
REQ-005 SHALL have parameter SUCCESS_ONLY, default 0: 0 = enqueue every finished job; 1 = enqueue only jobs with success=1.

Interface
REQ-006 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, NUM_CORES: per-core job-start pulse.
REQ-009 SHALL have port busy, input, NUM_CORES: per-core hashing-in-progress.
REQ-010 SHALL have port success, input, NUM_CORES: per-core nonce-found flag, valid when busy falls.
REQ-011 SHALL have port hash_id, input, NUM_CORES*ID_W: core i at [i*ID_W +: ID_W].
REQ-012 SHALL have port nonce_in, input, NUM_CORES*NONCE_W: core i at [i*NONCE_W +: NONCE_W].
REQ-013 SHALL have port flush, input, 1: synchronous clear of queued and pending results.
REQ-014 SHALL have port rd_ready, input, 1: consumer accepts head entry.
REQ-015 SHALL have port rd_valid, output, 1: FIFO non-empty.
REQ-016 SHALL have port rd_data, output, EW: head entry, EW = 1+CW+ID_W+NONCE_W, CW = max(1,clog2(NUM_CORES)).
REQ-017 SHALL have port fifo_count, output, clog2(DEPTH)+1: occupied entries.
REQ-018 SHALL have port overflow, output, 1: sticky result-lost flag.
REQ-019 SHALL have port drop_count, output, 8: saturating count of lost results.

Function
REQ-020 Per-core FSM SHALL have states IDLE, ARMED, RUN: IDLE->ARMED on start[i]; ARMED->RUN on busy[i]; RUN->IDLE on !busy[i]; otherwise hold.
REQ-021 On the RUN->IDLE edge, core i SHALL load hold[i] = {success[i], i[CW-1:0], hash_id[i], nonce_in[i]} and set pending[i], unless SUCCESS_ONLY=1 and success[i]=0 (nothing captured).
REQ-022 If capture hits a core whose pending[i] is still set, SHALL overwrite hold[i], set overflow, and increment drop_count.
REQ-023 Arbiter SHALL grant at most one pending core per cycle, round-robin, search starting at core after last grant; pointer resets to core 0.
REQ-024 A granted entry SHALL be written to FIFO and pending cleared at the same edge; a capture for the same core at that edge sets pending again with the new data.
REQ-025 Write SHALL occur when FIFO not full, or full with rd_valid&rd_ready same cycle (simultaneous read+write allowed, count unchanged).
REQ-026 When full and no read, grant SHALL be withheld and pending held (no loss at FIFO stage).
REQ-027 Read SHALL pop on rd_valid&rd_ready; rd_ready while empty SHALL have no effect.
REQ-028 rd_data SHALL be first-word-fall-through: head entry visible combinationally while rd_valid=1; value while empty is don't-care.
REQ-029 Latency: busy[i] sampled low at edge k (core in RUN, FIFO empty, no contention) -> rd_valid=1 after edge k+1.
REQ-030 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-031 drop_count SHALL saturate at 255.
REQ-032 flush SHALL at next edge empty FIFO, clear pending, clear overflow, zero drop_count, preserve per-core FSM states; flush wins over simultaneous capture, write and read.

Reset
REQ-033 reset SHALL at next edge set all FSMs IDLE, pending=0, FIFO empty, rd_valid=0, fifo_count=0, overflow=0, drop_count=0, arbiter pointer=0; reset mid-job discards that job.
REQ-034 Reset SHALL override flush and all other inputs.

Verification
REQ-035 NUM_CORES=4: core 2 start, busy 5 cycles, success=1, hash_id=4'hA, nonce=32'hDEADBEEF -> rd_valid one edge after busy low; rd_data={1,2'd2,4'hA,32'hDEADBEEF}.
REQ-036 Cores 0..3 all drop busy same cycle -> four entries in order 0,1,2,3 on consecutive edges; fifo_count reaches 4.
REQ-037 SUCCESS_ONLY=1, job ends success=0 -> no entry, fifo_count stays 0, overflow=0.
REQ-038 DEPTH=8, rd_ready=0, 9 jobs complete -> fifo_count=8, ninth held pending; one pop -> ninth enqueued, count back to 8.
REQ-039 FIFO full with core pending, new capture on that core -> overflow=1, drop_count=1; then flush -> count 0, overflow 0, drop_count 0.
REQ-040 reset asserted while core in RUN -> next edge all outputs zero, later busy fall produces no entry.
